load_store_unit: RTL and testbench

//  Sits between the MIPS MEM stage and datamemory. Converts byte/half/word load
//  and store requests into word accesses on datamemory (ADDR/WR_RD/din/dout).

---
 rtl/load_store_unit.sv | 114 +++++++++++
 tb/tb_load_store_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Byte/half/word load-store front end for a word-wide datamemory.
// Sub-word stores use read-modify-write; loads are sign/zero extended.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] dm_addr,
  output logic                  dm_wr_rd,
  output logic [DATA_WIDTH-1:0] dm_din,
  input  logic [DATA_WIDTH-1:0] dm_dout
);
  localparam int NUM_LANES = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, ACCESS, WAIT, WRITE, RESP} state_t;

  typedef struct packed {
    logic                  we;
    logic [1:0]            size;
    logic                  sgn;
    logic [ADDR_WIDTH+1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  state_t                state;
  req_t                  r;
  logic [DATA_WIDTH-1:0] mrg, merged, ld_data;
  logic [15:0]           lane;
  logic                  bad, word_st;
  logic                  unused_hi;

  assign bad = (req_size == 2'b11)
            || (req_size == 2'b01 && req_addr[0])
            || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  assign word_st   = r.we && (r.size == 2'b10);
  assign unused_hi = ^req_addr[DATA_WIDTH-1:ADDR_WIDTH+2];

  // Halves are always 2-byte aligned here, so one byte-granular shift serves both.
  assign lane = 16'(dm_dout >> {r.addr[1:0], 3'b000});

  always_comb begin
    ld_data = dm_dout;
    case (r.size)
      2'b00:   ld_data = {{(DATA_WIDTH-8){r.sgn & lane[7]}}, lane[7:0]};
      2'b01:   ld_data = {{(DATA_WIDTH-16){r.sgn & lane[15]}}, lane};
      default: ld_data = dm_dout;
    endcase
  end

  generate
    for (genvar b = 0; b < NUM_LANES; b++) begin : g_lane
      logic hit;
      assign hit = (r.size == 2'b00) ? (r.addr[1:0] == 2'(b))
                                     : (r.addr[1] == ((b / 2) != 0));
      assign merged[8*b +: 8] = !hit               ? dm_dout[8*b +: 8] :
                                (r.size == 2'b00)  ? r.wdata[7:0]      :
                                                     r.wdata[8*(b%2) +: 8];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      r          <= '0;
      mrg        <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          r          <= '{we: req_we, size: req_size, sgn: req_signed,
                          addr: req_addr[ADDR_WIDTH+1:0], wdata: req_wdata};
          resp_rdata <= '0;
          resp_err   <= bad;
          state      <= bad ? RESP : ACCESS;
        end
        ACCESS: state <= word_st ? RESP : WAIT;
        WAIT: if (r.we) begin
          mrg   <= merged;
          state <= WRITE;
        end else begin
          resp_rdata <= ld_data;
          state      <= RESP;
        end
        WRITE:   state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory strobes come straight from state so an async reset drops them at once.
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign dm_wr_rd   = (state == WRITE) || (state == ACCESS && word_st);
  assign dm_addr    = (state == IDLE) ? '0 : r.addr[ADDR_WIDTH+1:2];

  always_comb begin
    dm_din = '0;
    if (state == WRITE)                dm_din = mrg;
    else if (state == ACCESS && word_st) dm_din = r.wdata;
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-level reference memory model plus a
// per-cycle compare process, with directed vectors and literal expectations.
module tb_load_store_unit;
  logic        clk = 0, rst_n = 0;
  logic        req_valid = 0, req_we = 0, req_signed = 0;
  logic [1:0]  req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        req_ready, resp_valid, resp_err, dm_wr_rd;
  logic [31:0] resp_rdata, dm_din, dm_dout;
  logic [9:0]  dm_addr;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .dm_addr(dm_addr),
    .dm_wr_rd(dm_wr_rd), .dm_din(dm_din), .dm_dout(dm_dout));

  always #5 clk = ~clk;

  // datamemory: synchronous read, write on rising edge when WR_RD
  logic [31:0] mem [0:1023];
  logic        pl_en = 0;
  logic [9:0]  pl_a = 0;
  logic [31:0] pl_d = 0;
  always @(posedge clk) begin
    if (pl_en)         mem[pl_a]    <= pl_d;
    else if (dm_wr_rd) mem[dm_addr] <= dm_din;
    dm_dout <= mem[dm_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Reference model: byte-addressed memory and one outstanding request
  logic [7:0]  bmem [0:4095];
  bit          act = 0, mon_en = 0;
  int          a_cyc = 0, e_resp = -1, e_wr = -1;
  logic [31:0] e_rdata = 0, e_din = 0, e_addr = 0;
  logic        e_err = 0;
  logic [31:0] last_rdata = 0;
  logic        last_err = 0;
  int          last_resp_cyc = 0, wr_pulses = 0;

  task automatic model_accept(input bit we, input logic [1:0] size, input bit sgn,
                              input logic [31:0] addr, input logic [31:0] wd);
    int nb, ba, base, lat;
    logic [31:0] v;
    nb = 1 << size; ba = int'(addr[11:0]); base = ba & ~3;
    e_err  = (size == 2'b11) || (ba % nb != 0);
    a_cyc  = cyc + 1;
    e_addr = 32'(ba >> 2);
    lat    = e_err ? 1 : (!we ? 3 : (nb == 4 ? 2 : 4));
    e_resp = a_cyc + lat - 1;
    e_wr   = (e_err || !we) ? -1 : (nb == 4 ? a_cyc : a_cyc + 2);
    e_rdata = 0; e_din = 0;
    if (!e_err && !we) begin
      v = 0;
      for (int i = 0; i < nb; i++) v = v | (32'(bmem[ba+i]) << (8*i));
      if (sgn && nb < 4 && v[8*nb-1])
        for (int i = 8*nb; i < 32; i++) v[i] = 1'b1;
      e_rdata = v;
    end
    if (!e_err && we) begin
      for (int i = 0; i < nb; i++) bmem[ba+i] = wd[8*i +: 8];
      e_din = {bmem[base+3], bmem[base+2], bmem[base+1], bmem[base]};
    end
    act = 1;
  endtask

  // Compare process: every cycle while enabled
  always @(negedge clk) if (mon_en) begin
    bit busy, rv, wv;
    busy = act && cyc >= a_cyc && cyc <= e_resp;
    rv = busy && cyc == e_resp;
    wv = busy && cyc == e_wr;
    chk("req_ready", 32'(req_ready), 32'(!busy));
    chk("resp_valid", 32'(resp_valid), 32'(rv));
    chk("dm_wr_rd", 32'(dm_wr_rd), 32'(wv));
    chk("dm_addr", 32'(dm_addr), busy ? e_addr : 32'h0);
    if (dm_wr_rd) wr_pulses++;
    if (wv) chk("dm_din", dm_din, e_din);
    if (rv) begin
      chk("resp_rdata", resp_rdata, e_rdata);
      chk("resp_err", 32'(resp_err), 32'(e_err));
      last_rdata = resp_rdata; last_err = resp_err; last_resp_cyc = cyc;
    end
  end

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk); #1;
    pl_en = 1; pl_a = 10'(idx); pl_d = val;
    for (int i = 0; i < 4; i++) bmem[4*idx+i] = val[8*i +: 8];
    @(negedge clk); #1;
    pl_en = 0;
  endtask

  task automatic do_req(input bit we, input logic [1:0] size, input bit sgn,
                        input logic [31:0] addr, input logic [31:0] wd, input bit hold);
    int t;
    @(negedge clk); #1;
    t = 0;
    while (!req_ready && t < 20) begin @(negedge clk); #1; t++; end
    if (!req_ready) begin chk("ready_timeout", 32'(req_ready), 32'd1); return; end
    req_valid = 1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wd;
    model_accept(we, size, sgn, addr, wd);
    t = 0;
    do begin
      @(negedge clk); #1;
      if (hold) begin req_addr = $urandom; req_wdata = $urandom; req_we = ~req_we; end
      else req_valid = 0;
      t++;
    end while (cyc <= e_resp && t < 20);
    req_valid = 0;
    if (cyc <= e_resp) chk("resp_timeout", 32'(cyc), 32'(e_resp + 1));
  endtask

  task automatic chk_lat(input string nm, input int lat);
    chk(nm, 32'(last_resp_cyc - a_cyc + 1), 32'(lat));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int wp0, bad;
    for (int i = 0; i < 4096; i++) bmem[i] = 8'h00;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_dm_wr_rd", 32'(dm_wr_rd), 0);
    chk("rst_dm_addr", 32'(dm_addr), 0);
    chk("rst_dm_din", dm_din, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_err", 32'(resp_err), 0);
    rst_n = 1;
    @(negedge clk); #1;
    chk("rst_req_ready", 32'(req_ready), 1);
    mon_en = 1;

    // 1: word store then word load
    do_req(1, 2'b10, 0, 32'h004, 32'hDEADBEEF, 0);
    chk_lat("t1_st_lat", 2);
    do_req(0, 2'b10, 0, 32'h004, 32'h0, 0);
    chk_lat("t1_ld_lat", 3);
    chk("t1_ld_data", last_rdata, 32'hDEADBEEF);
    chk("t1_ld_err", 32'(last_err), 0);

    // 2: byte store via RMW
    preload(1, 32'h11223344);
    wp0 = wr_pulses;
    do_req(1, 2'b00, 0, 32'h006, 32'h123456AA, 0);
    chk_lat("t2_lat", 4);
    chk("t2_wr_pulses", 32'(wr_pulses - wp0), 1);
    chk("t2_mem1", mem[1], 32'h11AA3344);

    // 3: sub-word loads with extension, plus a half store
    preload(2, 32'h80F0007F);
    do_req(0, 2'b00, 1, 32'h008, 0, 0); chk("t3_lb_08", last_rdata, 32'h0000007F);
    do_req(0, 2'b00, 1, 32'h00A, 0, 0); chk("t3_lb_0a", last_rdata, 32'hFFFFFFF0);
    do_req(0, 2'b01, 0, 32'h00A, 0, 0); chk("t3_lhu_0a", last_rdata, 32'h000080F0);
    do_req(0, 2'b01, 1, 32'h00A, 0, 0); chk("t3_lh_0a", last_rdata, 32'hFFFF80F0);
    do_req(1, 2'b01, 0, 32'h002, 32'h9999CAFE, 0);
    chk("t3_sh_mem0", mem[0], 32'hCAFE0000);

    // 4: error requests
    wp0 = wr_pulses;
    do_req(0, 2'b10, 0, 32'h005, 0, 0);
    chk_lat("t4_lw_lat", 1); chk("t4_lw_err", 32'(last_err), 1); chk("t4_lw_data", last_rdata, 0);
    do_req(1, 2'b01, 0, 32'h003, 32'hFFFF, 0);
    chk_lat("t4_sh_lat", 1); chk("t4_sh_err", 32'(last_err), 1);
    do_req(0, 2'b11, 0, 32'h010, 0, 0);
    chk_lat("t4_rsv_lat", 1); chk("t4_rsv_err", 32'(last_err), 1);
    chk("t4_no_writes", 32'(wr_pulses - wp0), 0);

    // 5: reset in the middle of a byte-store RMW
    preload(3, 32'h12345678);
    mon_en = 0;
    @(negedge clk); #1;
    req_valid = 1; req_we = 1; req_size = 2'b00; req_signed = 0;
    req_addr = 32'h00C; req_wdata = 32'hAA;
    @(negedge clk); #1;
    req_valid = 0;
    @(negedge clk); #1;
    rst_n = 0;
    #1;
    chk("t5_wr_rd_async", 32'(dm_wr_rd), 0);
    chk("t5_addr_async", 32'(dm_addr), 0);
    chk("t5_resp_async", 32'(resp_valid), 0);
    repeat (3) begin
      @(negedge clk);
      chk("t5_resp_in_rst", 32'(resp_valid), 0);
      chk("t5_wr_in_rst", 32'(dm_wr_rd), 0);
    end
    #1 rst_n = 1;
    @(negedge clk); #1;
    chk("t5_ready", 32'(req_ready), 1);
    chk("t5_mem3", mem[3], 32'h12345678);
    mon_en = 1;
    do_req(0, 2'b10, 0, 32'h00C, 0, 0);
    chk("t5_readback", last_rdata, 32'h12345678);

    // 6: request held and scrambled while busy
    do_req(1, 2'b10, 0, 32'h014, 32'h5A5AA5A5, 1);
    do_req(0, 2'b10, 0, 32'h014, 0, 0);
    chk("t6_readback", last_rdata, 32'h5A5AA5A5);

    @(negedge clk); #1;
    mon_en = 0;
    bad = 0;
    for (int w = 0; w < 64; w++)
      if (mem[w] !== {bmem[4*w+3], bmem[4*w+2], bmem[4*w+1], bmem[4*w]}) bad++;
    chk("final_mem_words_differing", 32'(bad), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
